// File: rtl/nova_frame_buf_pkg.sv
// Shared definitions for the external frame buffer controller:
// control FSM encoding, legal parameter ranges and index rotation.
package nova_frame_buf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fb_state_e;

    localparam int NUM_BUF_MIN = 2;
    localparam int NUM_BUF_MAX = 4;
    localparam int RD_LAT_MIN  = 1;
    localparam int RD_LAT_MAX  = 4;

    // Next buffer in the rotation, wrapping after the last one
    function automatic logic [1:0] fb_next_idx(input logic [1:0] idx,
                                               input int num_buf);
        return (idx == 2'(num_buf - 1)) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/frame_buf_rd_pipe.sv
// Read-return pipeline: tracks in-flight reads and the buffer each one
// was issued to, then selects the matching RAM data when it returns.
module frame_buf_rd_pipe
    import nova_frame_buf_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NUM_BUF = 3,
    parameter int RD_LAT  = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      acc_i,
    input  logic [1:0]                idx_i,
    input  logic [NUM_BUF*DATA_W-1:0] ram_data_i,
    output logic [DATA_W-1:0]         dout_o,
    output logic                      valid_o,
    output logic                      busy_o
);

    localparam int DEPTH = RD_LAT + 1;

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("frame_buf_rd_pipe: RD_LAT out of range");
    end

    logic [DEPTH-1:0] vld_q;
    logic [1:0]       idx_q [DEPTH];

    // Shift each accepted read and its source buffer along with the RAM latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
        end else begin
            vld_q    <= {vld_q[DEPTH-2:0], acc_i};
            idx_q[0] <= idx_i;
            for (int i = 1; i < DEPTH; i++) idx_q[i] <= idx_q[i-1];
        end
    end

    // Returned word comes from the buffer captured at acceptance time
    always_comb begin
        dout_o = '0;
        for (int k = 0; k < NUM_BUF; k++) begin
            if (vld_q[DEPTH-1] && idx_q[DEPTH-1] == 2'(k))
                dout_o = ram_data_i[k*DATA_W +: DATA_W];
        end
    end

    assign valid_o = vld_q[DEPTH-1];
    assign busy_o  = |vld_q;

endmodule

// File: rtl/ext_frame_buf_ctrl.sv
// Rotates NUM_BUF external frame RAMs between display-write and
// reference-read roles, swapping once in-flight reads have drained.
module ext_frame_buf_ctrl
    import nova_frame_buf_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 14,
    parameter int NUM_BUF = 3,
    parameter int RD_LAT  = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      end_of_one_frame,
    input  logic                      ref_frame_RAM_rd,
    input  logic [ADDR_W-1:0]         ref_frame_RAM_rd_addr,
    output logic                      ref_rd_ready,
    output logic [DATA_W-1:0]         ref_frame_RAM_dout,
    output logic                      ref_dout_valid,
    input  logic                      dis_frame_RAM_wr,
    input  logic [ADDR_W-1:0]         dis_frame_RAM_wr_addr,
    output logic                      dis_wr_ready,
    output logic [NUM_BUF-1:0]        ext_RAM_cs_n,
    output logic [NUM_BUF-1:0]        ext_RAM_wr,
    output logic [NUM_BUF*ADDR_W-1:0] ext_RAM_addr,
    input  logic [NUM_BUF*DATA_W-1:0] ext_RAM_data,
    output logic [1:0]                wr_idx,
    output logic [1:0]                ref_idx,
    output logic                      ref_avail
);

    if (NUM_BUF < NUM_BUF_MIN || NUM_BUF > NUM_BUF_MAX) begin : g_bad_num_buf
        $error("ext_frame_buf_ctrl: NUM_BUF out of range");
    end

    fb_state_e state_q;
    logic [1:0] wr_idx_q, wr_idx_d, ref_idx_q;
    logic avail_q, rd_rdy_q, wr_rdy_q;
    logic rd_acc, wr_acc, busy;
    logic [NUM_BUF-1:0] cs_n_q, wr_q;
    logic [NUM_BUF*ADDR_W-1:0] addr_q;

    assign rd_acc   = ref_frame_RAM_rd & rd_rdy_q;
    assign wr_acc   = dis_frame_RAM_wr & wr_rdy_q;
    assign wr_idx_d = fb_next_idx(wr_idx_q, NUM_BUF);

    // Role FSM: swap on first frame end, later swaps wait for reads to drain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            wr_idx_q  <= 2'd0;
            ref_idx_q <= 2'(NUM_BUF - 1);
            avail_q   <= 1'b0;
            rd_rdy_q  <= 1'b0;
            wr_rdy_q  <= 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: if (end_of_one_frame) begin
                    state_q   <= ST_RUN;
                    ref_idx_q <= wr_idx_q;
                    wr_idx_q  <= wr_idx_d;
                    avail_q   <= 1'b1;
                    rd_rdy_q  <= 1'b1;
                end
                ST_RUN: if (end_of_one_frame) begin
                    state_q  <= ST_DRAIN;
                    rd_rdy_q <= 1'b0;
                    wr_rdy_q <= 1'b0;
                end
                ST_DRAIN: if (!busy) begin
                    state_q   <= ST_RUN;
                    ref_idx_q <= wr_idx_q;
                    wr_idx_q  <= wr_idx_d;
                    avail_q   <= 1'b1;
                    rd_rdy_q  <= 1'b1;
                    wr_rdy_q  <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Registered per-buffer strobes; idle buffers keep their last address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_n_q <= '1;
            wr_q   <= '0;
            addr_q <= '0;
        end else begin
            for (int k = 0; k < NUM_BUF; k++) begin
                if (wr_acc && wr_idx_q == 2'(k)) begin
                    cs_n_q[k] <= 1'b0;
                    wr_q[k]   <= 1'b1;
                    addr_q[k*ADDR_W +: ADDR_W] <= dis_frame_RAM_wr_addr;
                end else if (rd_acc && ref_idx_q == 2'(k)) begin
                    cs_n_q[k] <= 1'b0;
                    wr_q[k]   <= 1'b0;
                    addr_q[k*ADDR_W +: ADDR_W] <= ref_frame_RAM_rd_addr;
                end else begin
                    cs_n_q[k] <= 1'b1;
                    wr_q[k]   <= 1'b0;
                end
            end
        end
    end

    frame_buf_rd_pipe #(
        .DATA_W  (DATA_W),
        .NUM_BUF (NUM_BUF),
        .RD_LAT  (RD_LAT)
    ) u_rd_pipe (
        .clk        (clk),
        .reset_n    (reset_n),
        .acc_i      (rd_acc),
        .idx_i      (ref_idx_q),
        .ram_data_i (ext_RAM_data),
        .dout_o     (ref_frame_RAM_dout),
        .valid_o    (ref_dout_valid),
        .busy_o     (busy)
    );

    assign ref_rd_ready = rd_rdy_q;
    assign dis_wr_ready = wr_rdy_q;
    assign ext_RAM_cs_n = cs_n_q;
    assign ext_RAM_wr   = wr_q;
    assign ext_RAM_addr = addr_q;
    assign wr_idx       = wr_idx_q;
    assign ref_idx      = ref_idx_q;
    assign ref_avail    = avail_q;

endmodule

// File: tb/tb_ext_frame_buf_ctrl.sv
// Bench for ext_frame_buf_ctrl: two instances (3 buffers / latency 3 and
// 2 buffers / latency 2) driven together and checked against a model.
module tb_ext_frame_buf_ctrl;

    localparam int DW = 32;
    localparam int AW = 14;

    logic clk = 1'b0;
    logic reset_n;
    logic eof, rd, wr;
    logic [AW-1:0] rd_addr, wr_addr;

    logic [1:0]    o_widx [2];
    logic [1:0]    o_ridx [2];
    logic          o_avail[2];
    logic          o_rrdy [2];
    logic          o_wrdy [2];
    logic          o_vld  [2];
    logic [DW-1:0] o_dout [2];
    logic [3:0]    o_cs   [2];
    logic [3:0]    o_we   [2];
    logic [AW-1:0] o_ad   [2][4];

    always #5 clk = ~clk;

    function automatic int nb_of(input int i);
        return (i == 0) ? 3 : 2;
    endfunction

    function automatic int rl_of(input int i);
        return (i == 0) ? 3 : 2;
    endfunction

    // Contents of external RAM k at address a
    function automatic logic [DW-1:0] pat(input int k, input logic [AW-1:0] a);
        logic [7:0] kk;
        kk = 8'(k + 1);
        if (a == 14'h0055) return 32'hA5A5A5A5 ^ DW'(k);
        return {kk, 10'h0, a};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int NB = (g == 0) ? 3 : 2;
        localparam int RL = (g == 0) ? 3 : 2;
        logic [NB-1:0]    cs_n, we;
        logic [NB*AW-1:0] ad;
        logic [NB*DW-1:0] rdata;
        logic [AW-1:0]    rpipe [NB][RL];
        logic [1:0]       widx, ridx;
        logic             avail, rrdy, wrdy, vld;
        logic [DW-1:0]    dout;

        ext_frame_buf_ctrl #(
            .DATA_W(DW), .ADDR_W(AW), .NUM_BUF(NB), .RD_LAT(RL)
        ) u_dut (
            .clk                   (clk),
            .reset_n               (reset_n),
            .end_of_one_frame      (eof),
            .ref_frame_RAM_rd      (rd),
            .ref_frame_RAM_rd_addr (rd_addr),
            .ref_rd_ready          (rrdy),
            .ref_frame_RAM_dout    (dout),
            .ref_dout_valid        (vld),
            .dis_frame_RAM_wr      (wr),
            .dis_frame_RAM_wr_addr (wr_addr),
            .dis_wr_ready          (wrdy),
            .ext_RAM_cs_n          (cs_n),
            .ext_RAM_wr            (we),
            .ext_RAM_addr          (ad),
            .ext_RAM_data          (rdata),
            .wr_idx                (widx),
            .ref_idx               (ridx),
            .ref_avail             (avail)
        );

        // External RAM: address sampled each edge, data RL cycles later
        always @(posedge clk) begin
            for (int k = 0; k < NB; k++) begin
                rpipe[k][0] <= ad[k*AW +: AW];
                for (int s = 1; s < RL; s++) rpipe[k][s] <= rpipe[k][s-1];
            end
        end

        assign o_widx[g]  = widx;
        assign o_ridx[g]  = ridx;
        assign o_avail[g] = avail;
        assign o_rrdy[g]  = rrdy;
        assign o_wrdy[g]  = wrdy;
        assign o_vld[g]   = vld;
        assign o_dout[g]  = dout;

        for (genvar k = 0; k < 4; k++) begin : g_b
            if (k < NB) begin : g_on
                assign rdata[k*DW +: DW] = pat(k, rpipe[k][RL-1]);
                assign o_cs[g][k]  = cs_n[k];
                assign o_we[g][k]  = we[k];
                assign o_ad[g][k]  = ad[k*AW +: AW];
            end else begin : g_off
                assign o_cs[g][k]  = 1'b1;
                assign o_we[g][k]  = 1'b0;
                assign o_ad[g][k]  = '0;
            end
        end
    end

    // ---------------- behavioural model ----------------
    typedef struct {
        int inst;
        int ret;
        int b;
        int a;
    } rd_t;

    rd_t rq[$];
    int  m_mode [2];
    int  m_wr   [2];
    int  m_ref  [2];
    int  m_avail[2];
    int  m_cs   [2][4];
    int  m_we   [2][4];
    int  m_ad   [2][4];
    int  cyc;
    int  total;
    int  bad;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        rq.delete();
        for (int i = 0; i < 2; i++) begin
            m_mode[i]  = 0;
            m_wr[i]    = 0;
            m_ref[i]   = nb_of(i) - 1;
            m_avail[i] = 0;
            for (int k = 0; k < 4; k++) begin
                m_cs[i][k] = 1;
                m_we[i][k] = 0;
                m_ad[i][k] = 0;
            end
        end
    endtask

    task automatic swap(input int i);
        m_ref[i]   = m_wr[i];
        m_wr[i]    = (m_wr[i] + 1) % nb_of(i);
        m_avail[i] = 1;
    endtask

    // Advance the model across the edge that ends cycle cyc
    task automatic model_step();
        for (int j = rq.size() - 1; j >= 0; j--)
            if (rq[j].ret < cyc) rq.delete(j);
        for (int i = 0; i < 2; i++) begin
            int  nb, rl;
            bit  busy, racc, wacc;
            nb = nb_of(i);
            rl = rl_of(i);
            busy = 0;
            foreach (rq[j])
                if (rq[j].inst == i && cyc >= rq[j].ret - rl && cyc <= rq[j].ret)
                    busy = 1;
            racc = rd && (m_mode[i] == 1);
            wacc = wr && (m_mode[i] != 2);
            for (int k = 0; k < nb; k++) begin
                m_cs[i][k] = 1;
                m_we[i][k] = 0;
                if (wacc && k == m_wr[i]) begin
                    m_cs[i][k] = 0;
                    m_we[i][k] = 1;
                    m_ad[i][k] = int'(wr_addr);
                end else if (racc && k == m_ref[i]) begin
                    m_cs[i][k] = 0;
                    m_ad[i][k] = int'(rd_addr);
                end
            end
            if (racc) rq.push_back('{i, cyc + 1 + rl, m_ref[i], int'(rd_addr)});
            if (m_mode[i] == 0 && eof) begin
                swap(i);
                m_mode[i] = 1;
            end else if (m_mode[i] == 1 && eof) begin
                m_mode[i] = 2;
            end else if (m_mode[i] == 2 && !busy) begin
                swap(i);
                m_mode[i] = 1;
            end
        end
    endtask

    task automatic compare();
        for (int i = 0; i < 2; i++) begin
            logic          ev;
            logic [DW-1:0] ed;
            logic [3:0]    ecs, ewe;
            ev = 1'b0;
            ed = '0;
            foreach (rq[j])
                if (rq[j].inst == i && rq[j].ret == cyc) begin
                    ev = 1'b1;
                    ed = pat(rq[j].b, AW'(rq[j].a));
                end
            for (int k = 0; k < 4; k++) begin
                ecs[k] = (m_cs[i][k] != 0);
                ewe[k] = (m_we[i][k] != 0);
            end
            chk($sformatf("u%0d wr_idx", i), o_widx[i], m_wr[i]);
            chk($sformatf("u%0d ref_idx", i), o_ridx[i], m_ref[i]);
            chk($sformatf("u%0d ref_avail", i), o_avail[i], m_avail[i]);
            chk($sformatf("u%0d ref_rd_ready", i), o_rrdy[i], m_mode[i] == 1);
            chk($sformatf("u%0d dis_wr_ready", i), o_wrdy[i], m_mode[i] != 2);
            chk($sformatf("u%0d dout_valid", i), o_vld[i], ev);
            chk($sformatf("u%0d dout", i), o_dout[i], ed);
            chk($sformatf("u%0d cs_n", i), o_cs[i], ecs);
            chk($sformatf("u%0d wr", i), o_we[i], ewe);
            for (int k = 0; k < 4; k++)
                chk($sformatf("u%0d addr%0d", i, k), o_ad[i][k], m_ad[i][k]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_step();
        cyc++;
        #1;
        compare();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        eof = 0;
        rd = 0;
        wr = 0;
        rd_addr = '0;
        wr_addr = '0;
        reset_n = 1'b1;
        model_reset();
        #1 reset_n = 1'b0;
        tick();
        tick();
        chk("rst wr_idx A", o_widx[0], 0);
        chk("rst ref_idx A", o_ridx[0], 2);
        chk("rst ref_idx B", o_ridx[1], 1);
        chk("rst avail A", o_avail[0], 0);
        chk("rst cs_n A", o_cs[0], 4'b1111);
        reset_n = 1'b1;
        tick();

        // writes with no frame pulse land on buffer 0
        for (int n = 0; n < 4; n++) begin
            wr = 1;
            wr_addr = AW'(n);
            tick();
            chk("wr cs_n0 A", o_cs[0][0], 0);
            chk("wr wr0 A", o_we[0][0], 1);
            chk("wr addr0 A", o_ad[0][0], n);
            chk("wr cs_n0 B", o_cs[1][0], 0);
            chk("wr rd_ready A", o_rrdy[0], 0);
            chk("wr avail A", o_avail[0], 0);
        end
        wr = 0;

        // first pulse: swap visible next cycle
        eof = 1;
        tick();
        eof = 0;
        chk("p1 wr_idx A", o_widx[0], 1);
        chk("p1 ref_idx A", o_ridx[0], 0);
        chk("p1 wr_idx B", o_widx[1], 1);
        chk("p1 ref_idx B", o_ridx[1], 0);
        chk("p1 avail A", o_avail[0], 1);

        // read 0x55: latency RD_LAT+1
        rd = 1;
        rd_addr = 14'h0055;
        tick();
        rd = 0;
        chk("rd cs_n0 A", o_cs[0][0], 0);
        chk("rd wr0 A", o_we[0][0], 0);
        chk("rd addr0 A", o_ad[0][0], 14'h0055);
        tick();
        tick();
        chk("rd t+3 valid A", o_vld[0], 0);
        chk("rd t+3 valid B", o_vld[1], 1);
        chk("rd t+3 dout B", o_dout[1], 32'hA5A5A5A5);
        tick();
        chk("rd t+4 valid A", o_vld[0], 1);
        chk("rd t+4 dout A", o_dout[0], 32'hA5A5A5A5);
        tick();
        tick();

        // read then pulse: drain holds until the read returns
        rd = 1;
        rd_addr = 14'h0012;
        tick();
        rd = 0;
        eof = 1;
        tick();
        eof = 0;
        chk("dr r+2 rd_ready B", o_rrdy[1], 0);
        chk("dr r+2 rd_ready A", o_rrdy[0], 0);
        chk("dr r+2 wr_ready B", o_wrdy[1], 0);
        tick();
        chk("dr r+3 valid B", o_vld[1], 1);
        chk("dr r+3 dout B", o_dout[1], 32'h01000012);
        chk("dr r+3 ref_idx B", o_ridx[1], 0);
        eof = 1;
        tick();
        eof = 0;
        chk("dr r+4 rd_ready B", o_rrdy[1], 0);
        chk("dr r+4 valid A", o_vld[0], 1);
        chk("dr r+4 dout A", o_dout[0], 32'h01000012);
        tick();
        chk("dr r+5 rd_ready B", o_rrdy[1], 1);
        chk("dr r+5 wr_idx B", o_widx[1], 0);
        chk("dr r+5 ref_idx B", o_ridx[1], 1);
        chk("dr r+5 rd_ready A", o_rrdy[0], 0);
        tick();
        chk("dr r+6 rd_ready A", o_rrdy[0], 1);
        chk("p2 wr_idx A", o_widx[0], 2);
        chk("p2 ref_idx A", o_ridx[0], 1);

        // third pulse wraps the 3-buffer rotation
        eof = 1;
        tick();
        eof = 0;
        tick();
        chk("p3 wr_idx A", o_widx[0], 0);
        chk("p3 ref_idx A", o_ridx[0], 2);
        chk("p3 wr_idx B", o_widx[1], 1);
        chk("p3 ref_idx B", o_ridx[1], 0);

        // write coinciding with the pulse uses the old write buffer
        wr = 1;
        wr_addr = 14'h0077;
        eof = 1;
        tick();
        wr = 0;
        eof = 0;
        chk("wf cs_n0 A", o_cs[0][0], 0);
        chk("wf wr0 A", o_we[0][0], 1);
        chk("wf addr0 A", o_ad[0][0], 14'h0077);
        chk("wf cs_n1 B", o_cs[1][1], 0);
        tick();
        wr = 1;
        wr_addr = 14'h0078;
        tick();
        wr = 0;
        chk("wn cs_n1 A", o_cs[0][1], 0);
        chk("wn addr1 A", o_ad[0][1], 14'h0078);
        chk("wn cs_n0 B", o_cs[1][0], 0);
        chk("wn wr0 B", o_we[1][0], 1);

        // reset in the middle of a read burst
        rd = 1;
        for (int n = 0; n < 5; n++) begin
            rd_addr = AW'(14'h0100 + n);
            tick();
        end
        #3;
        reset_n = 1'b0;
        rd = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("ar valid", o_vld[i], 0);
            chk("ar dout", o_dout[i], 0);
            chk("ar cs_n", o_cs[i], 4'b1111);
            chk("ar wr", o_we[i], 0);
            chk("ar addr0", o_ad[i][0], 0);
            chk("ar addr1", o_ad[i][1], 0);
            chk("ar wr_idx", o_widx[i], 0);
            chk("ar ref_idx", o_ridx[i], nb_of(i) - 1);
            chk("ar avail", o_avail[i], 0);
            chk("ar rd_ready", o_rrdy[i], 0);
            chk("ar wr_ready", o_wrdy[i], 1);
        end
        model_reset();
        tick();
        #2;
        reset_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            tick();
            chk("post-rst valid A", o_vld[0], 0);
            chk("post-rst valid B", o_vld[1], 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
